// File: rtl/scan_sched.sv
// scan_sched: periodic scan sync generator and per-channel frame readout arbiter
module scan_sched #(
  parameter int NCH    = 4,
  parameter int WORDS  = 4096,
  parameter int SETTLE = 8,
  parameter int TMO    = 1024
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               i_enable,
  input  logic [23:0]        i_period,
  input  logic               i_clr,
  output logic               o_send_sync,
  input  logic [32*NCH-1:0]  i_ch_data,
  input  logic [NCH-1:0]     i_ch_vld,
  output logic [NCH-1:0]     o_ch_rdy,
  output logic [31:0]        o_data,
  output logic               o_vld,
  input  logic               i_rdy,
  output logic               o_sof,
  output logic               o_eof,
  output logic               o_busy,
  output logic               o_overrun,
  output logic               o_tmo_err,
  output logic [19:0]        o_frame_cnt
);
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int WW = $clog2(WORDS + 1);
  localparam int TW = $clog2(TMO + 1);
  localparam int DW = $clog2(SETTLE + 5);
  typedef enum logic [2:0] {IDLE, SYNC, WAIT, HDR, DATA, PAD, NEXT} state_t;
  state_t state, nxt;
  logic [23:0] cnt, per, p_eff;
  logic [CW-1:0] ch;
  logic [WW-1:0] wcnt;
  logic [TW-1:0] tcnt;
  logic [DW-1:0] dly;
  logic [31:0] ch_data;
  logic expire, last_ch, last_word, ch_vld, xfer, tmo_hit;
  // at count 0 the live i_period is used so a new period takes effect right at the wrap
  assign p_eff = cnt == '0 ? (i_period < 24'd2 ? 24'd2 : i_period) : per;
  assign expire = i_enable && cnt == p_eff - 24'd1;
  assign last_ch = ch == CW'(NCH - 1);
  assign last_word = wcnt == WW'(WORDS - 1);
  assign ch_data = i_ch_data[32*ch +: 32];
  assign ch_vld = i_ch_vld[ch];
  assign xfer = ch_vld && i_rdy;
  assign tmo_hit = !ch_vld && tcnt == TW'(TMO - 1);
  assign o_busy = state != IDLE;
  // period counter: free-runs while enabled, period latched at each wrap
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      per <= 24'd2;
    end else begin
      cnt <= (!i_enable || expire) ? '0 : cnt + 24'd1;
      per <= p_eff;
    end
  // state register
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // channel, word, timeout and delay counters plus sticky flags
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      ch          <= '0;
      wcnt        <= '0;
      tcnt        <= '0;
      dly         <= '0;
      o_frame_cnt <= '0;
      o_overrun   <= 1'b0;
      o_tmo_err   <= 1'b0;
    end else begin
      dly <= state != nxt ? '0 : dly + 1'b1;
      if (state == IDLE && nxt == SYNC) o_frame_cnt <= o_frame_cnt + 20'd1;
      if (state == WAIT) ch <= '0;
      else if (state == NEXT && !last_ch) ch <= ch + 1'b1;
      if (state == HDR) begin
        wcnt <= '0;
        tcnt <= '0;
      end else if (state == DATA) begin
        if (xfer) begin
          wcnt <= wcnt + 1'b1;
          tcnt <= '0;
        end else if (!ch_vld) tcnt <= tcnt + 1'b1;
      end else if (state == PAD && i_rdy) wcnt <= wcnt + 1'b1;
      o_overrun <= (expire && state != IDLE) || (o_overrun && !i_clr);
      o_tmo_err <= (state == DATA && tmo_hit) || (o_tmo_err && !i_clr);
    end
  // next state and merged stream outputs
  always_comb begin
    nxt = state;
    o_send_sync = 1'b0;
    o_vld = 1'b0;
    o_data = '0;
    o_sof = 1'b0;
    o_eof = 1'b0;
    o_ch_rdy = '0;
    case (state)
      IDLE: nxt = expire ? SYNC : IDLE;
      SYNC: begin
        o_send_sync = 1'b1;
        nxt = dly == DW'(3) ? WAIT : SYNC;
      end
      WAIT: nxt = dly == DW'(SETTLE - 1) ? HDR : WAIT;
      HDR: begin
        o_vld = 1'b1;
        o_data = {8'hA5, 4'(ch), o_frame_cnt};
        o_sof = ch == '0;
        nxt = i_rdy ? DATA : HDR;
      end
      DATA: begin
        o_vld = ch_vld;
        o_data = ch_data;
        o_ch_rdy[ch] = i_rdy;
        o_eof = last_ch && last_word && ch_vld;
        nxt = (xfer && last_word) ? NEXT : tmo_hit ? PAD : DATA;
      end
      PAD: begin
        o_vld = 1'b1;
        o_data = 32'hDEAD_0000 | 32'(wcnt);
        o_eof = last_ch && last_word;
        nxt = (i_rdy && last_word) ? NEXT : PAD;
      end
      NEXT: nxt = last_ch ? IDLE : HDR;
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_scan_sched.sv
// tb_scan_sched: directed scoreboard bench for the scan frame scheduler
module tb_scan_sched;
  localparam int NCH = 2, WORDS = 8, SETTLE = 8, TMO = 16;
  typedef struct packed {logic [31:0] d; logic sof; logic eof; logic [NCH-1:0] m; logic fp;} ent_t;
  logic sys_clk = 1'b0, rst, i_enable, i_clr, i_rdy;
  logic [23:0] i_period;
  logic [32*NCH-1:0] i_ch_data;
  logic [NCH-1:0] i_ch_vld, o_ch_rdy;
  logic [31:0] o_data;
  logic o_send_sync, o_vld, o_sof, o_eof, o_busy, o_overrun, o_tmo_err;
  logic [19:0] o_frame_cnt;
  ent_t q[$];
  int total = 0, bad = 0, cyc_n = 0, sync_n = 0, sync_len = 0, last_rise = -1, fall_cyc = 0;
  int exp_period = 0, exp_frame = 0, stall_n = 0, s0;
  int ch_word[NCH], exp_word[NCH], stuck_at[NCH];
  logic prev_sync = 1'b0, prev_busy = 1'b0, want_sof = 1'b0, tog = 1'b0;

  scan_sched #(.NCH(NCH), .WORDS(WORDS), .SETTLE(SETTLE), .TMO(TMO)) dut (
    .sys_clk(sys_clk), .rst(rst), .i_enable(i_enable), .i_period(i_period), .i_clr(i_clr),
    .o_send_sync(o_send_sync), .i_ch_data(i_ch_data), .i_ch_vld(i_ch_vld), .o_ch_rdy(o_ch_rdy),
    .o_data(o_data), .o_vld(o_vld), .i_rdy(i_rdy), .o_sof(o_sof), .o_eof(o_eof), .o_busy(o_busy),
    .o_overrun(o_overrun), .o_tmo_err(o_tmo_err), .o_frame_cnt(o_frame_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int sc, input int sa);
    ent_t e;
    exp_frame++;
    for (int c = 0; c < NCH; c++) begin
      e = '{d: {8'hA5, 4'(c), 20'(exp_frame)}, sof: c == 0, eof: 1'b0, m: '0, fp: 1'b0};
      q.push_back(e);
      for (int i = 0; i < WORDS; i++) begin
        if (c == sc && i >= sa) begin
          e.d = 32'hDEAD_0000 | 32'(i);
          e.m = '0;
          e.fp = i == sa;
        end else begin
          e.d = 32'hC000_0000 | (32'(c) << 16) | 32'(exp_word[c]);
          exp_word[c]++;
          e.m = NCH'(1 << c);
          e.fp = 1'b0;
        end
        e.sof = 1'b0;
        e.eof = c == NCH - 1 && i == WORDS - 1;
        q.push_back(e);
      end
    end
  endtask

  task automatic cyc();
    ent_t e;
    @(negedge sys_clk);
    if (o_send_sync && !prev_sync) begin
      sync_n++;
      chk("sync_from_idle", 32'(prev_busy), 0);
      if (exp_period > 0 && last_rise >= 0) chk("period", cyc_n - last_rise, exp_period);
      last_rise = cyc_n;
    end
    if (o_send_sync) sync_len++;
    if (!o_send_sync && prev_sync) begin
      chk("sync_len", sync_len, 4);
      sync_len = 0;
      fall_cyc = cyc_n;
      want_sof = 1'b1;
    end
    if (q.size() == 0) chk("spurious_vld", 32'(o_vld), 0);
    else if (o_vld) begin
      e = q[0];
      chk("data", o_data, e.d);
      chk("sof_eof", 32'({o_sof, o_eof}), 32'({e.sof, e.eof}));
      chk("ch_rdy", 32'(o_ch_rdy), 32'(e.m & {NCH{i_rdy}}));
      if (e.sof && want_sof) begin
        chk("settle", cyc_n - fall_cyc, SETTLE);
        want_sof = 1'b0;
      end
      if (e.fp) begin
        chk("tmo_gap", stall_n, TMO);
        chk("tmo_err_set", 32'(o_tmo_err), 1);
      end
      if (i_rdy) void'(q.pop_front());
    end
    stall_n = (o_busy && !o_vld && q.size() > 0 && (q[0].m != 0 || q[0].fp)) ? stall_n + 1 : 0;
    for (int k = 0; k < NCH; k++) if (o_ch_rdy[k] && i_ch_vld[k]) ch_word[k]++;
    prev_sync = o_send_sync;
    prev_busy = o_busy;
    cyc_n++;
    @(posedge sys_clk);
    #1;
    for (int k = 0; k < NCH; k++) begin
      i_ch_data[32*k +: 32] = 32'hC000_0000 | (32'(k) << 16) | 32'(ch_word[k]);
      i_ch_vld[k] = ch_word[k] < stuck_at[k];
    end
    if (tog) i_rdy = !i_rdy;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (q.size() > 0 && n < bound) begin
      cyc();
      n++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; i_enable = 1'b0; i_clr = 1'b0; i_rdy = 1'b1; i_period = 24'd200;
    i_ch_data = '0; i_ch_vld = '0;
    for (int k = 0; k < NCH; k++) begin
      ch_word[k] = 0; exp_word[k] = 0; stuck_at[k] = 32'h7fff_ffff;
    end
    cyc(); cyc();
    chk("rst_outs", 32'({o_send_sync, o_vld, o_sof, o_eof, o_busy, o_overrun, o_tmo_err, o_ch_rdy}), 0);
    chk("rst_data", o_data, 0);
    chk("rst_frame_cnt", 32'(o_frame_cnt), 0);
    rst = 1'b0;
    cyc();
    // basic frames, period 200
    exp_period = 200;
    push_frame(-1, 0); push_frame(-1, 0);
    i_enable = 1'b1;
    drain(700);
    chk("frame_cnt_2", 32'(o_frame_cnt), 2);
    chk("sync_cnt_2", sync_n, 2);
    // backpressure: ready toggles every cycle
    tog = 1'b1;
    push_frame(-1, 0);
    drain(400);
    tog = 1'b0; i_rdy = 1'b1;
    chk("xfers_ch0", ch_word[0], exp_word[0]);
    chk("xfers_ch1", ch_word[1], exp_word[1]);
    // timeout on ch1 after 3 words
    chk("tmo_err_pre", 32'(o_tmo_err), 0);
    stuck_at[1] = ch_word[1] + 3;
    push_frame(1, 3);
    drain(400);
    chk("tmo_err_sticky", 32'(o_tmo_err), 1);
    chk("no_overrun_200", 32'(o_overrun), 0);
    stuck_at[1] = 32'h7fff_ffff;
    i_clr = 1'b1; cyc(); i_clr = 1'b0;
    chk("tmo_err_clr", 32'(o_tmo_err), 0);
    i_enable = 1'b0; exp_period = 0; last_rise = -1;
    cyc(); cyc();
    // overrun with period 10
    i_period = 24'd10;
    push_frame(-1, 0);
    i_enable = 1'b1;
    drain(300);
    chk("overrun_set", 32'(o_overrun), 1);
    i_enable = 1'b0;
    cyc(); cyc(); cyc();
    i_clr = 1'b1; cyc(); i_clr = 1'b0;
    chk("overrun_clr", 32'(o_overrun), 0);
    push_frame(-1, 0);
    i_enable = 1'b1;
    repeat (19) cyc();
    chk("overrun_before", 32'(o_overrun), 0);
    cyc();
    chk("overrun_busy_expiry", 32'(o_overrun), 1);
    repeat (9) cyc();
    i_clr = 1'b1; cyc(); i_clr = 1'b0;
    chk("set_beats_clr", 32'(o_overrun), 1);
    // enable dropped mid-DATA
    i_enable = 1'b0;
    s0 = sync_n;
    drain(200);
    repeat (40) cyc();
    chk("no_sync_after_disable", sync_n, s0);
    chk("idle_after_disable", 32'(o_busy), 0);
    chk("frame_cnt_6", 32'(o_frame_cnt), 6);
    // async reset mid-DATA
    i_period = 24'd12;
    push_frame(-1, 0);
    i_enable = 1'b1;
    repeat (28) cyc();
    chk("mid_data_busy", 32'(o_busy), 1);
    rst = 1'b1; i_enable = 1'b0;
    #1;
    chk("rst_mid_outs", 32'({o_send_sync, o_vld, o_sof, o_eof, o_busy, o_overrun, o_tmo_err, o_ch_rdy}), 0);
    chk("rst_mid_frame_cnt", 32'(o_frame_cnt), 0);
    q.delete();
    for (int k = 0; k < NCH; k++) exp_word[k] = ch_word[k];
    exp_frame = 0; prev_sync = 1'b0; prev_busy = 1'b0; sync_len = 0; stall_n = 0; want_sof = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    // minimum period
    i_period = 24'd0;
    push_frame(-1, 0);
    i_enable = 1'b1;
    cyc();
    chk("minp_no_sync_yet", 32'(o_send_sync), 0);
    cyc();
    chk("minp_sync", 32'(o_send_sync), 1);
    drain(200);
    chk("minp_overrun", 32'(o_overrun), 1);
    chk("minp_frame_cnt", 32'(o_frame_cnt), 1);
    i_enable = 1'b0;
    repeat (10) cyc();
    chk("minp_idle", 32'(o_busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/scan_sched.md
Name: scan_sched

Overview:
- Frame scheduler and readout arbiter for NCH full-scan receive channels, all in the sys_clk domain.
- Periodically issues the scan sync pulse to every channel. After a settle delay, drains each channel's buffered scan in fixed order into one merged output stream.
- Each channel's burst is preceded by a header word.
- Sits between the channel readout streams and the host DMA/packet path.

Parameters:
- NCH, 4, number of channels (1..16)
- WORDS, 4096, data words drained per channel per frame
- SETTLE, 8, sys_clk cycles between o_send_sync fall and first header
- TMO, 1024, max consecutive cycles the selected channel's vld may stay low in DATA before abort

Ports:
- sys_clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_enable  in  1  1 = run periodic frames
- i_period  in  24  frame period in sys_clk cycles; values <2 treated as 2
- i_clr  in  1  clears o_overrun and o_tmo_err sticky flags
- o_send_sync  out  1  sync pulse to all channels
- i_ch_data  in  32*NCH  channel stream data, ch k at [32k+31:32k]
- i_ch_vld  in  NCH  channel stream valid
- o_ch_rdy  out  NCH  channel stream ready
- o_data  out  32  merged stream data
- o_vld  out  1  merged stream valid
- i_rdy  in  1  merged stream ready
- o_sof  out  1  high with first header of a frame
- o_eof  out  1  high with last word of a frame
- o_busy  out  1  state != IDLE
- o_overrun  out  1  sticky: period elapsed while frame still busy
- o_tmo_err  out  1  sticky: a channel burst was aborted by timeout
- o_frame_cnt  out  20  frames started since reset

Behaviour:
- Reset: all outputs 0, state IDLE, period counter 0, frame_cnt 0.
- Period counter:
  - Free-runs 0..P-1 while i_enable=1, where P = max(i_period, 2). Expiry = count==P-1; the counter then wraps to 0.
  - With i_enable=0 the counter is held at 0.
  - i_period is sampled at each wrap.
- Expiry in IDLE: go to SYNC.
- Expiry in any other state: set o_overrun (sticky); no new sync, current frame continues.
- State machine:
  - IDLE: waits for expiry.
  - SYNC: o_send_sync=1 for exactly 4 cycles (survives the channel 2-flop edge detector), then WAIT. frame_cnt increments on SYNC entry.
  - WAIT: SETTLE cycles with o_send_sync=0; then ch=0, go to HDR.
  - HDR: o_vld=1, o_data={8'hA5, 4'(ch), frame_cnt[19:0]}. o_sof=1 when ch==0. On i_rdy: word counter=0, tmo counter=0, go to DATA.
  - DATA: combinational pass-through o_data=i_ch_data[ch], o_vld=i_ch_vld[ch], o_ch_rdy[ch]=i_rdy; all other o_ch_rdy bits 0.
    - A transfer is vld&rdy; each transfer increments the word counter.
    - Transfer with counter==WORDS-1 ends the burst, go to NEXT. o_eof=1 on that word if ch==NCH-1.
  - Timeout in DATA:
    - tmo counter increments each cycle i_ch_vld[ch]=0 and resets on any transfer.
    - At TMO: set o_tmo_err, go to PAD.
  - PAD: emits 32'hDEAD_0000|word_counter words with o_vld=1 until the word counter reaches WORDS (the burst length is always WORDS+1 including header); o_ch_rdy=0. Then NEXT. o_eof rule is the same as DATA.
  - NEXT: ch==NCH-1 → IDLE; else ch+1, go to HDR. NEXT lasts 1 cycle.
- Output stream: o_vld/o_data must stay stable while o_vld & ~i_rdy in HDR and PAD. In DATA, stability is inherited from the channel.
- i_enable falling mid-frame: the frame completes normally and no further sync is issued.
- i_clr and a flag-set in the same cycle: set wins.
- Asynchronous rst mid-frame: immediate return to reset values. A partially sent burst is abandoned and the downstream must resync on 0xA5 header + o_sof.
- Widths: word counter is clog2(WORDS+1) bits; tmo counter is clog2(TMO+1) bits; frame_cnt wraps at 2^20.

Test Plan:
- Basic frame: NCH=2, WORDS=8, i_period=200, channels always valid, i_rdy=1.
  - o_send_sync high 4 cycles, then 8 idle cycles.
  - Output: header A5_0_00001, 8 ch0 words, header A5_1_00001, 8 ch1 words.
  - o_sof on first header, o_eof on the 18th word; repeats every 200 cycles.
- Backpressure: i_rdy toggles 1/0 every cycle during HDR and DATA.
  - Header data stable while stalled.
  - o_ch_rdy follows i_rdy only for the active channel.
  - Exactly 8 transfers per channel.
- Overrun: i_period=10 with WORDS=8.
  - Expiry during DATA sets o_overrun; no second sync until IDLE.
  - i_clr clears it; i_clr coincident with a new overrun leaves it 1.
- Timeout: ch1 vld stuck low after 3 words, TMO=16.
  - After 16 idle cycles o_tmo_err=1.
  - 5 words DEAD0003..DEAD0007 are emitted with o_eof on the last.
- Enable/reset: i_enable dropped mid-DATA → frame completes, no further o_send_sync.
  - rst pulsed mid-DATA → all outputs 0 next cycle; o_frame_cnt=0.
- Min period: i_period=0 → treated as 2; sync occurs on first expiry, and later expiries only set o_overrun while busy.
